// File: rtl/cpu_pkg.sv
// Shared types for the 5-stage pipeline controller:
// FSM states, stage-control bundle and its canned settings.
package cpu_pkg;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic memwb_we;
    logic memwb_bubble;
  } stage_ctl_t;

  localparam stage_ctl_t ALL_RUN = '{
    pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
    idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1,
    memwb_we: 1'b1, memwb_bubble: 1'b0
  };

  // MEM_WB keeps loading, but only a bubble
  localparam stage_ctl_t ALL_FREEZE = '{
    pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
    idex_we: 1'b0, idex_flush: 1'b0, exmem_we: 1'b0,
    memwb_we: 1'b1, memwb_bubble: 1'b1
  };

  localparam stage_ctl_t ALL_RESET = '{
    pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
    idex_we: 1'b0, idex_flush: 1'b1, exmem_we: 1'b0,
    memwb_we: 1'b0, memwb_bubble: 1'b1
  };

  function automatic logic is_load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return mem_read && (rd != REG_ZERO) &&
           ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle counter for an outstanding data-memory access;
// expire flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller: load-use stalls, branch flushes,
// multi-cycle data-memory freeze with timeout.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RD_i,
  input  logic [4:0]       IFID_RS_i,
  input  logic [4:0]       IFID_RT_i,
  input  logic             Branch_taken_i,
  input  logic             Dmem_req_i,
  input  logic             Dmem_ack_i,
  output logic             Dmem_start_o,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Write_o,
  output logic             IDEX_Flush_o,
  output logic             EXMEM_Write_o,
  output logic             MEMWB_Write_o,
  output logic             MEMWB_Bubble_o,
  output logic [CNT_W-1:0] Stall_cnt_o,
  output logic             Err_o
);

  state_t     state, state_nx;
  stage_ctl_t ctl, hz_ctl;
  logic       load_use;
  logic       start, err_set;
  logic       tmr_clr, tmr_en, expire;
  logic [CNT_W-1:0] stall_cnt;
  logic             err;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(expire)
  );

  assign load_use = is_load_use(IDEX_MemRead_i, IDEX_RD_i,
                                IFID_RS_i, IFID_RT_i);

  // load-use beats branch: branch re-resolves next cycle
  always_comb begin
    hz_ctl = ALL_RUN;
    unique case (1'b1)
      load_use: begin
        hz_ctl.pc_we      = 1'b0;
        hz_ctl.ifid_we    = 1'b0;
        hz_ctl.idex_flush = 1'b1;
      end
      (Branch_taken_i && !load_use): begin
        hz_ctl.ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ctl      = ALL_RUN;
    state_nx = state;
    start    = 1'b0;
    err_set  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state)
      RUN: begin
        if (Dmem_req_i) begin
          ctl      = ALL_FREEZE;
          start    = 1'b1;
          tmr_clr  = 1'b1;
          state_nx = MEM_WAIT;
        end else begin
          ctl = hz_ctl;
        end
      end
      MEM_WAIT: begin
        if (Dmem_ack_i || expire) begin
          ctl      = hz_ctl;
          err_set  = !Dmem_ack_i;
          state_nx = RUN;
        end else begin
          ctl    = ALL_FREEZE;
          tmr_en = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
    if (!rst_i) begin
      ctl      = ALL_RESET;
      start    = 1'b0;
      err_set  = 1'b0;
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= RUN;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (!ctl.pc_we && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  assign Dmem_start_o   = start;
  assign PC_Write_o     = ctl.pc_we;
  assign IFID_Write_o   = ctl.ifid_we;
  assign IFID_Flush_o   = ctl.ifid_flush;
  assign IDEX_Write_o   = ctl.idex_we;
  assign IDEX_Flush_o   = ctl.idex_flush;
  assign EXMEM_Write_o  = ctl.exmem_we;
  assign MEMWB_Write_o  = ctl.memwb_we;
  assign MEMWB_Bubble_o = ctl.memwb_bubble;
  assign Stall_cnt_o    = stall_cnt;
  assign Err_o          = err;

endmodule
